// File: rtl/rgb_level_arbiter_if.sv
// Bundle for rgb_level_arbiter: per-channel requests, readback select, and the
// grant/level/readback/busy outputs. The master drives requests; the arbiter is the slave.
interface rgb_level_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [2:0]       req;
  logic [2:0]       req_dir;
  logic [1:0]       enc_sel;
  logic [2:0]       grant;
  logic [WIDTH-1:0] level0;
  logic [WIDTH-1:0] level1;
  logic [WIDTH-1:0] level2;
  logic [WIDTH-1:0] enc_val;
  logic             busy;

  modport master (
    output req, req_dir, enc_sel,
    input  grant, level0, level1, level2, enc_val, busy
  );

  modport slave (
    input  req, req_dir, enc_sel,
    output grant, level0, level1, level2, enc_val, busy
  );
endinterface

// File: rtl/rgb_level_arbiter.sv
// Three RGB channel levels sharing one +/-1 datapath through an IDLE -> READ -> WRITE FSM
// with round-robin arbitration. One committed update every three cycles.
// Optional feature: define RGB_LEVEL_WRAP_EN to wrap at the level bounds instead of saturating.
module rgb_level_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  rgb_level_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;      // last granted channel
  logic [1:0]       win_q;      // channel owning the transaction in flight
  logic [WIDTH-1:0] op_q;
  logic             dir_q;
  logic [2:0]       grant_q;
  logic             busy_q;
  logic [WIDTH-1:0] level_q [3];
  logic [WIDTH-1:0] enc_q;

  logic [1:0]       rr_win;
  logic [WIDTH-1:0] win_level;
  logic             win_dir;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] enc_mux;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin pick: search starts at the channel after the last grant.
  always_comb begin
    logic [1:0] c0;
    logic [1:0] c1;
    c0 = rr_next(ptr_q);
    c1 = rr_next(c0);
    rr_win = ptr_q;
    if (bus.req[c0]) begin
      rr_win = c0;
    end else if (bus.req[c1]) begin
      rr_win = c1;
    end
  end

  // Operand source for the READ state.
  always_comb begin
    win_level = level_q[0];
    win_dir   = bus.req_dir[0];
    unique case (win_q)
      2'd1: begin
        win_level = level_q[1];
        win_dir   = bus.req_dir[1];
      end
      2'd2: begin
        win_level = level_q[2];
        win_dir   = bus.req_dir[2];
      end
      default: begin
        win_level = level_q[0];
        win_dir   = bus.req_dir[0];
      end
    endcase
  end

  // Shared adder/subtractor with bound handling.
  always_comb begin
`ifdef RGB_LEVEL_WRAP_EN
    op_res = dir_q ? op_q + WIDTH'(1) : op_q - WIDTH'(1);
`else
    op_res = op_q;
    if (dir_q && (op_q != '1)) begin
      op_res = op_q + WIDTH'(1);
    end else if (!dir_q && (op_q != '0)) begin
      op_res = op_q - WIDTH'(1);
    end
`endif
  end

  // Readback select; code 3 reads as zero.
  always_comb begin
    enc_mux = '0;
    unique case (bus.enc_sel)
      2'd0:    enc_mux = level_q[0];
      2'd1:    enc_mux = level_q[1];
      2'd2:    enc_mux = level_q[2];
      default: enc_mux = '0;
    endcase
  end

  // FSM, level registers, grant pulse and readback register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd2;
      win_q      <= 2'd0;
      op_q       <= '0;
      dir_q      <= 1'b0;
      grant_q    <= 3'b000;
      busy_q     <= 1'b0;
      level_q[0] <= '0;
      level_q[1] <= '0;
      level_q[2] <= '0;
      enc_q      <= '0;
    end else begin
      grant_q <= 3'b000;
      enc_q   <= enc_mux;
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            win_q   <= rr_win;
            busy_q  <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          op_q    <= win_level;
          dir_q   <= win_dir;
          state_q <= StWrite;
        end
        StWrite: begin
          for (int i = 0; i < 3; i++) begin
            if (win_q == 2'(i)) begin
              level_q[i] <= op_res;
            end
          end
          grant_q <= 3'b001 << win_q;
          ptr_q   <= win_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.level0  = level_q[0];
  assign bus.level1  = level_q[1];
  assign bus.level2  = level_q[2];
  assign bus.enc_val = enc_q;

endmodule

// File: tb/tb_rgb_level_arbiter.sv
// Directed bench for rgb_level_arbiter: expected grants/levels are queued when a request is
// driven and popped when the grant pulse appears.
module tb_rgb_level_arbiter;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [2:0]   g;
    logic [1:0]   ch;
    logic [W-1:0] lvl;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   grant_cyc;
  int   req_cyc;
  exp_t exp_q[$];
  logic [W-1:0] m_lvl [3];

  rgb_level_arbiter_if #(.WIDTH(W)) bus ();

  rgb_level_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] lvl(input logic [1:0] ch);
    case (ch)
      2'd0:    return bus.level0;
      2'd1:    return bus.level1;
      default: return bus.level2;
    endcase
  endfunction

  function automatic logic [W-1:0] model_next(input logic [W-1:0] v, input logic dir);
`ifdef RGB_LEVEL_WRAP_EN
    return dir ? v + 8'd1 : v - 8'd1;
`else
    if (dir) return (v == 8'hff) ? v : v + 8'd1;
    return (v == 8'h00) ? v : v - 8'd1;
`endif
  endfunction

  // Queue an expected commit for channel ch and advance the model.
  task automatic push_exp(input int ch, input logic dir);
    exp_t e;
    m_lvl[ch] = model_next(m_lvl[ch], dir);
    e.g   = 3'b001 << ch;
    e.ch  = 2'(ch);
    e.lvl = m_lvl[ch];
    exp_q.push_back(e);
  endtask

  // mode 0: drop the granted req bit; 1: keep all reqs; 2: drop all reqs.
  task automatic wait_and_check(input int mode);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.grant != 3'b000) seen = 1'b1;
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $error("FAIL grant_timeout observed=none expected=grant");
      return;
    end
    grant_cyc = cyc;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL unexpected_grant observed=%b expected=none", bus.grant);
      return;
    end
    e = exp_q.pop_front();
    check("grant", 32'(bus.grant), 32'(e.g));
    if (mode == 0) bus.req = bus.req & ~bus.grant;
    else if (mode == 2) bus.req = 3'b000;
    @(negedge clk);
    check("level", 32'(lvl(e.ch)), 32'(e.lvl));
  endtask

  task automatic do_update(input int ch, input logic dir);
    logic [2:0] m;
    m = 3'b001 << ch;
    bus.req_dir = dir ? m : 3'b000;
    bus.req     = m;
    push_exp(ch, dir);
    wait_and_check(0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_lvl[i] = '0;
    exp_q.delete();
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    cyc         = 0;
    grant_cyc   = 0;
    rst         = 1'b1;
    bus.req     = 3'b000;
    bus.req_dir = 3'b000;
    bus.enc_sel = 2'd0;
    for (int i = 0; i < 3; i++) m_lvl[i] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_level0", 32'(bus.level0), 0);
    check("rst_level1", 32'(bus.level1), 0);
    check("rst_level2", 32'(bus.level2), 0);
    check("rst_enc", 32'(bus.enc_val), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single channel-0 increment: latency 3, busy for two cycles
    bus.req_dir = 3'b001;
    bus.req     = 3'b001;
    req_cyc     = cyc;
    push_exp(0, 1'b1);
    @(negedge clk);
    check("busy_c1", 32'(bus.busy), 1);
    check("grant_c1", 32'(bus.grant), 0);
    @(negedge clk);
    check("busy_c2", 32'(bus.busy), 1);
    check("grant_c2", 32'(bus.grant), 0);
    wait_and_check(0);
    check("latency", 32'(grant_cyc - req_cyc), 3);
    check("busy_after", 32'(bus.busy), 0);

    // All three requesting continuously: 001, 010, 100, 001 at 3-cycle spacing
    do_reset();
    bus.req_dir = 3'b111;
    bus.req     = 3'b111;
    req_cyc     = cyc;
    push_exp(0, 1'b1);
    push_exp(1, 1'b1);
    push_exp(2, 1'b1);
    push_exp(0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_and_check(k == 3 ? 2 : 1);
      check("spacing", 32'(grant_cyc - req_cyc), 3);
      req_cyc = grant_cyc;
    end
    repeat (3) begin
      @(negedge clk);
      check("idle_no_grant", 32'(bus.grant), 0);
    end

    // Decrement at zero on channel 2 (level2 is 1 here)
    do_update(2, 1'b0);
    do_update(2, 1'b0);
`ifdef RGB_LEVEL_WRAP_EN
    check("dec_bound_l2", 32'(bus.level2), 255);
`else
    check("dec_bound_l2", 32'(bus.level2), 0);
`endif

    // Increment channel 1 up to the top, then once more
    while (m_lvl[1] != 8'hff) do_update(1, 1'b1);
    check("l1_top", 32'(bus.level1), 255);
    do_update(1, 1'b1);
`ifdef RGB_LEVEL_WRAP_EN
    check("inc_bound_l1", 32'(bus.level1), 0);
`else
    check("inc_bound_l1", 32'(bus.level1), 255);
`endif

    // Readback sweep with levels 10/20/30
    do_reset();
    for (int i = 0; i < 10; i++) do_update(0, 1'b1);
    for (int i = 0; i < 20; i++) do_update(1, 1'b1);
    for (int i = 0; i < 30; i++) do_update(2, 1'b1);
    bus.enc_sel = 2'd3;
    @(negedge clk);
    check("enc_sel3_init", 32'(bus.enc_val), 0);
    begin
      logic [W-1:0] enc_exp [4];
      logic [W-1:0] prev;
      enc_exp[0] = 8'd10;
      enc_exp[1] = 8'd20;
      enc_exp[2] = 8'd30;
      enc_exp[3] = 8'd0;
      prev = 8'd0;
      for (int s = 0; s < 4; s++) begin
        bus.enc_sel = 2'(s);
        #1;
        check("enc_hold", 32'(bus.enc_val), 32'(prev));
        @(negedge clk);
        check("enc_val", 32'(bus.enc_val), 32'(enc_exp[s]));
        prev = enc_exp[s];
      end
    end
    bus.enc_sel = 2'd0;

    // Reset during READ of a channel-0 increment from 5
    do_reset();
    for (int i = 0; i < 5; i++) do_update(0, 1'b1);
    check("l0_five", 32'(bus.level0), 5);
    bus.req_dir = 3'b001;
    bus.req     = 3'b001;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 1);
    rst     = 1'b1;
    bus.req = 3'b000;
    #1;
    check("abort_level0", 32'(bus.level0), 0);
    check("abort_busy_rst", 32'(bus.busy), 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_grant", 32'(bus.grant), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_lvl[i] = '0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_grant", 32'(bus.grant), 0);
    end
    check("abort_level1", 32'(bus.level1), 0);
    check("abort_level2", 32'(bus.level2), 0);

    // First post-reset grant goes to channel 0, and commits even with req dropped in READ
    bus.req_dir = 3'b111;
    bus.req     = 3'b111;
    push_exp(0, 1'b1);
    @(negedge clk);
    bus.req = 3'b000;
    wait_and_check(2);
    repeat (4) begin
      @(negedge clk);
      check("post_no_grant", 32'(bus.grant), 0);
    end
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
